// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto a single shared memory port.
// One transaction at a time: grant in IDLE, LAT memory cycles in BUSY,
// a one-cycle completion pulse in DONE. Ties alternate via round-robin.
module mem_arbiter #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_wen,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last;      // 1: dcache held the previous grant
    logic             owner_d;   // 1: transaction in flight belongs to dcache
    logic             wr;        // transaction in flight is a write
    logic             grant_d_c;

    // Arbitration: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        grant_d_c = d_req && (!i_req || !last);
    end

    // Transaction FSM with registered memory-side and completion outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            owner_d <= 1'b0;
            wr      <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wen   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            m_wen   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        owner_d <= grant_d_c;
                        last    <= grant_d_c;
                        wr      <= grant_d_c && d_wen;
                        m_addr  <= grant_d_c ? d_addr : i_addr;
                        if (grant_d_c) begin
                            m_wdata <= d_wdata;
                        end
                        cnt   <= CNT_INIT;
                        state <= S_BUSY;
                        busy  <= 1'b1;
                        // With a single memory cycle the first BUSY cycle is also the last.
                        if (LAT == 1) begin
                            m_wen <= grant_d_c && d_wen;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) begin
                        if (!wr) begin
                            if (owner_d) begin
                                d_rdata <= m_rdata;
                            end else begin
                                i_rdata <= m_rdata;
                            end
                        end
                        if (owner_d) begin
                            d_ready <= 1'b1;
                        end else begin
                            i_ready <= 1'b1;
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            m_wen <= wr;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (grant time, ready time, data, memory image).
module tb_mem_arbiter;

    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LAT=2 instance
    logic        reset, i_req, i_ready, d_req, d_wen, d_ready, m_wen, busy;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;

    // LAT=1 instance
    logic        reset1, i_req1, i_ready1, d_req1, d_wen1, d_ready1, m_wen1, busy1;
    logic [31:0] i_addr1, i_rdata1, d_addr1, d_wdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;

    mem_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_rdata(m_rdata),
        .busy(busy)
    );

    mem_arbiter #(.LAT(1)) dut1 (
        .clk(clk), .reset(reset1),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ready(i_ready1),
        .d_req(d_req1), .d_wen(d_wen1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_ready(d_ready1),
        .m_addr(m_addr1), .m_wdata(m_wdata1), .m_wen(m_wen1), .m_rdata(m_rdata1),
        .busy(busy1)
    );

    // Bench memory behind the LAT=2 instance, with a preload port.
    logic [31:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (m_wen) mem[m_addr[7:0]] <= m_wdata;
    end
    assign m_rdata  = mem[m_addr[7:0]];
    assign m_rdata1 = 32'hA5A5_0000 | {24'h0, m_addr1[7:0]};

    // Reference model state
    logic [31:0] ref_mem [256];
    logic [31:0] exp_i_rdata, exp_d_rdata;
    int pass_cnt = 0;
    int total    = 0;

    function automatic logic [31:0] init_val(input int a);
        return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0203);
    endfunction

    task automatic test_reset();
        total++; if (i_ready !== 1'b0) $display("FAIL reset_i_ready got %0b want 0", i_ready); else pass_cnt++;
        total++; if (d_ready !== 1'b0) $display("FAIL reset_d_ready got %0b want 0", d_ready); else pass_cnt++;
        total++; if (i_rdata !== 32'h0) $display("FAIL reset_i_rdata got %h want 0", i_rdata); else pass_cnt++;
        total++; if (d_rdata !== 32'h0) $display("FAIL reset_d_rdata got %h want 0", d_rdata); else pass_cnt++;
        total++; if (m_addr !== 32'h0) $display("FAIL reset_m_addr got %h want 0", m_addr); else pass_cnt++;
        total++; if (m_wdata !== 32'h0) $display("FAIL reset_m_wdata got %h want 0", m_wdata); else pass_cnt++;
        total++; if (m_wen !== 1'b0) $display("FAIL reset_m_wen got %0b want 0", m_wen); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
        reset  = 1'b0;
        reset1 = 1'b0;
        @(negedge clk);
    endtask

    // Both ports held high: grants alternate icache, dcache, icache, dcache.
    task automatic test_tie();
        int period;
        logic exp_i, exp_d;
        period = LAT + 2;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_addr = 32'h20; d_wen = 1'b0;
        for (int t = 1; t <= 4 * period; t++) begin
            @(negedge clk);
            exp_i = 1'b0; exp_d = 1'b0;
            if (t >= LAT + 1 && (t - (LAT + 1)) % period == 0) begin
                if (((t - (LAT + 1)) / period) % 2 == 0) exp_i = 1'b1;
                else exp_d = 1'b1;
            end
            total++; if (i_ready !== exp_i) $display("FAIL tie_i_ready t=%0d got %0b want %0b", t, i_ready, exp_i); else pass_cnt++;
            total++; if (d_ready !== exp_d) $display("FAIL tie_d_ready t=%0d got %0b want %0b", t, d_ready, exp_d); else pass_cnt++;
            if (exp_i) begin
                exp_i_rdata = ref_mem[8'h10];
                total++; if (i_rdata !== exp_i_rdata) $display("FAIL tie_i_rdata got %h want %h", i_rdata, exp_i_rdata); else pass_cnt++;
            end
            if (exp_d) begin
                exp_d_rdata = ref_mem[8'h20];
                total++; if (d_rdata !== exp_d_rdata) $display("FAIL tie_d_rdata got %h want %h", d_rdata, exp_d_rdata); else pass_cnt++;
            end
            if (t == 4 * period - 1) begin
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        logic wen_seen;
        pl_en = 1'b1; pl_addr = 8'h40; pl_data = 32'h1234;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[8'h40] = 32'h1234;
        wen_seen = 1'b0;
        i_req = 1'b1; i_addr = 32'h40;
        for (int t = 1; t <= LAT + 3; t++) begin
            @(negedge clk);
            wen_seen = wen_seen | m_wen;
            total++; if (i_ready !== (t == LAT + 1)) $display("FAIL read_i_ready t=%0d got %0b", t, i_ready); else pass_cnt++;
            if (t == LAT + 1) begin
                i_req = 1'b0;
                exp_i_rdata = 32'h1234;
                total++; if (i_rdata !== exp_i_rdata) $display("FAIL read_i_rdata got %h want %h", i_rdata, exp_i_rdata); else pass_cnt++;
            end
        end
        total++; if (wen_seen !== 1'b0) $display("FAIL read_m_wen got %0b want 0", wen_seen); else pass_cnt++;
    endtask

    // dcache write; request fields are scrambled once the transaction is in flight.
    task automatic test_write();
        int pulses;
        pulses = 0;
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF;
        for (int t = 1; t <= LAT + 2; t++) begin
            @(negedge clk);
            if (t == 1) begin
                d_addr = 32'hFF; d_wdata = 32'h0; d_wen = 1'b0;
            end
            if (m_wen) pulses++;
            if (t <= LAT + 1) begin
                total++; if (m_addr !== 32'h80) $display("FAIL write_m_addr t=%0d got %h want 00000080", t, m_addr); else pass_cnt++;
            end
            total++; if (m_wen !== (t == LAT)) $display("FAIL write_m_wen t=%0d got %0b", t, m_wen); else pass_cnt++;
            total++; if (d_ready !== (t == LAT + 1)) $display("FAIL write_d_ready t=%0d got %0b", t, d_ready); else pass_cnt++;
            if (t == LAT + 1) begin
                d_req = 1'b0;
                total++; if (d_rdata !== exp_d_rdata) $display("FAIL write_d_rdata got %h want %h", d_rdata, exp_d_rdata); else pass_cnt++;
            end
        end
        ref_mem[8'h80] = 32'hDEADBEEF;
        total++; if (pulses != 1) $display("FAIL write_pulses got %0d want 1", pulses); else pass_cnt++;
        total++; if (mem[8'h80] !== 32'hDEADBEEF) $display("FAIL write_mem got %h want deadbeef", mem[8'h80]); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h90; d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL abort_busy got %0b want 1", busy); else pass_cnt++;
        reset = 1'b1;
        d_req = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy_rst got %0b want 0", busy); else pass_cnt++;
        total++; if (m_addr !== 32'h0) $display("FAIL abort_m_addr got %h want 0", m_addr); else pass_cnt++;
        total++; if (m_wdata !== 32'h0) $display("FAIL abort_m_wdata got %h want 0", m_wdata); else pass_cnt++;
        total++; if (i_rdata !== 32'h0) $display("FAIL abort_i_rdata got %h want 0", i_rdata); else pass_cnt++;
        total++; if (d_rdata !== 32'h0) $display("FAIL abort_d_rdata got %h want 0", d_rdata); else pass_cnt++;
        exp_i_rdata = 32'h0; exp_d_rdata = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < LAT + 3; t++) begin
            @(negedge clk);
            total++; if (m_wen !== 1'b0) $display("FAIL abort_m_wen t=%0d got %0b want 0", t, m_wen); else pass_cnt++;
            total++; if (d_ready !== 1'b0) $display("FAIL abort_d_ready t=%0d got %0b want 0", t, d_ready); else pass_cnt++;
        end
        total++; if (mem[8'h90] !== ref_mem[8'h90]) $display("FAIL abort_mem got %h want %h", mem[8'h90], ref_mem[8'h90]); else pass_cnt++;
    endtask

    // LAT=1 instance with dcache request held high across three transactions.
    task automatic test_back_to_back();
        logic exp_r;
        d_req1 = 1'b1; d_wen1 = 1'b0; d_addr1 = 32'h33;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            exp_r = (t >= 2) && ((t - 2) % 3 == 0) && (t <= 8);
            total++; if (d_ready1 !== exp_r) $display("FAIL b2b_d_ready t=%0d got %0b want %0b", t, d_ready1, exp_r); else pass_cnt++;
            total++; if (m_wen1 !== 1'b0 || i_ready1 !== 1'b0) $display("FAIL b2b_idle_port t=%0d got wen=%0b iready=%0b", t, m_wen1, i_ready1); else pass_cnt++;
            if (exp_r) begin
                total++; if (d_rdata1 !== 32'hA5A5_0033) $display("FAIL b2b_d_rdata got %h want a5a50033", d_rdata1); else pass_cnt++;
            end
            if (t == 8) d_req1 = 1'b0;
        end
        total++; if (busy1 !== 1'b0 || i_rdata1 !== 32'h0 || m_wdata1 !== 32'h0)
            $display("FAIL b2b_final got busy=%0b i_rdata=%h m_wdata=%h want 0", busy1, i_rdata1, m_wdata1); else pass_cnt++;
    endtask

    // Random traffic vs. a transaction-level model of grants, timing and data.
    task automatic test_random();
        int   free_cyc, ready_cyc, bad;
        logic pending, owner_d, is_wr, last_d, gd, exp_i, exp_d, exp_w;
        logic [7:0]  addr;
        logic [31:0] exp_data;
        free_cyc = 0; ready_cyc = -1; pending = 1'b0; owner_d = 1'b0; is_wr = 1'b0;
        last_d = 1'b1; exp_data = '0;
        for (int k = 0; k < 400; k++) begin
            exp_i = pending && !owner_d && (k == ready_cyc);
            exp_d = pending && owner_d && (k == ready_cyc);
            exp_w = pending && is_wr && (k == ready_cyc - 1);
            total++; if (i_ready !== exp_i) $display("FAIL rnd_i_ready k=%0d got %0b want %0b", k, i_ready, exp_i); else pass_cnt++;
            total++; if (d_ready !== exp_d) $display("FAIL rnd_d_ready k=%0d got %0b want %0b", k, d_ready, exp_d); else pass_cnt++;
            total++; if (m_wen !== exp_w) $display("FAIL rnd_m_wen k=%0d got %0b want %0b", k, m_wen, exp_w); else pass_cnt++;
            if (exp_i) begin
                exp_i_rdata = exp_data;
                total++; if (i_rdata !== exp_i_rdata) $display("FAIL rnd_i_rdata k=%0d got %h want %h", k, i_rdata, exp_i_rdata); else pass_cnt++;
            end
            if (exp_d) begin
                if (!is_wr) exp_d_rdata = exp_data;
                total++; if (d_rdata !== exp_d_rdata) $display("FAIL rnd_d_rdata k=%0d got %h want %h", k, d_rdata, exp_d_rdata); else pass_cnt++;
            end
            if (k == ready_cyc) pending = 1'b0;
            // requesters: keep/drop after completion, otherwise hold or randomly raise
            if (i_req && exp_i) i_req = 1'($urandom_range(0, 1));
            else if (!i_req) i_req = ($urandom_range(0, 2) == 0);
            if (d_req && exp_d) d_req = 1'($urandom_range(0, 1));
            else if (!d_req) d_req = ($urandom_range(0, 2) == 0);
            if (k >= 390) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            i_addr  = $urandom();
            d_addr  = $urandom();
            d_wdata = $urandom();
            d_wen   = 1'($urandom_range(0, 1));
            if (k >= free_cyc && (i_req || d_req)) begin
                gd        = d_req && (!i_req || !last_d);
                last_d    = gd;
                pending   = 1'b1;
                owner_d   = gd;
                is_wr     = gd && d_wen;
                addr      = gd ? d_addr[7:0] : i_addr[7:0];
                ready_cyc = k + 1 + LAT;
                free_cyc  = k + LAT + 2;
                if (is_wr) ref_mem[addr] = d_wdata;
                else exp_data = ref_mem[addr];
            end
            @(negedge clk);
        end
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
        total++; if (bad != 0) $display("FAIL rnd_mem_image got %0d differing words want 0", bad); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; reset1 = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0;
        i_req1 = 1'b0; i_addr1 = '0; d_req1 = 1'b0; d_wen1 = 1'b0; d_addr1 = '0; d_wdata1 = '0;
        exp_i_rdata = '0; exp_d_rdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            pl_en = 1'b1; pl_addr = 8'(a); pl_data = init_val(a);
            ref_mem[a] = init_val(a);
            @(negedge clk);
        end
        pl_en = 1'b0;
        test_reset();
        test_tie();
        test_single_read();
        test_write();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
